// File: rtl/prog_loader.sv
// Serial program loader: sync byte, 32-bit word count, data words, checksum; writes imem and holds core in reset.
// Latency: each completed word is written one cycle after its 4th byte; status outputs update on the accepting edge.
// Backpressure: none; a byte is consumed on every rx_valid cycle, and an idle gap of TIMEOUT_CYC aborts a load.
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   rx_data, rx_valid     byte stream from the serial receiver (one-cycle strobe per byte)
//   imem_we/addr/wdata    instruction-memory write port, one pulse per loaded word
//   core_rst              holds the core in reset unless a verified program is present
//   done, err             load verified / last load failed
module prog_loader #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    localparam int          TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;

    state_t            state;
    logic [1:0]        byte_idx;
    logic [31:0]       shreg;      // little-endian assembly, shared by length and data words
    logic [ADDR_W:0]   word_cnt;   // N fits here once it has passed the depth check
    logic [ADDR_W:0]   widx;
    logic [7:0]        csum;
    logic [TW-1:0]     tcnt;

    logic [31:0] assembled;
    logic        timeout_hit;

    // New bytes enter at the top so the first byte of a group ends up in bits 7:0.
    assign assembled   = {rx_data, shreg[31:8]};
    assign timeout_hit = (tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_idx   <= '0;
            shreg      <= '0;
            word_cnt   <= '0;
            widx       <= '0;
            csum       <= '0;
            tcnt       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (rx_valid && rx_data == 8'hA5) begin
                        state     <= LEN;
                        byte_idx  <= '0;
                        shreg     <= '0;
                        widx      <= '0;
                        imem_addr <= '0;
                        csum      <= '0;
                        tcnt      <= '0;
                        core_rst  <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                default: begin
                    // LEN, DATA, CHK: 0xA5 is ordinary payload here.
                    if (rx_valid) begin
                        tcnt     <= '0;
                        byte_idx <= byte_idx + 2'd1;
                        shreg    <= assembled;
                        case (state)
                            LEN: begin
                                if (byte_idx == 2'd3) begin
                                    word_cnt <= assembled[ADDR_W:0];
                                    if ({1'b0, assembled} > DEPTH) begin
                                        state <= ERR;
                                        err   <= 1'b1;
                                    end else if (assembled == 32'd0) begin
                                        state <= CHK;
                                    end else begin
                                        state <= DATA;
                                    end
                                end
                            end
                            DATA: begin
                                csum <= csum + rx_data;
                                if (byte_idx == 2'd3) begin
                                    imem_we    <= 1'b1;
                                    imem_addr  <= widx[ADDR_W-1:0];
                                    imem_wdata <= assembled;
                                    widx       <= widx + 1'b1;
                                    // Leave DATA on the same edge so a checksum byte
                                    // arriving next cycle is already seen in CHK.
                                    if (widx + 1'b1 == word_cnt)
                                        state <= CHK;
                                end
                            end
                            CHK: begin
                                if (rx_data == csum) begin
                                    state    <= DONE;
                                    done     <= 1'b1;
                                    core_rst <= 1'b0;
                                end else begin
                                    state <= ERR;
                                    err   <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (timeout_hit) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
